// File: rtl/logs_mixer_pkg.sv
// Shared definitions for the weighted audio mixer: modulator mode encodings,
// gain reset value and the raw-sum width helper.
package logs_mixer_pkg;

    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_SD  = 1'b1;

    // Unity gain after reset keeps the mix equal to a plain popcount.
    localparam int GAIN_RST = 1;

    function automatic int sum_width(input int n, input int w);
        return $clog2(n * ((1 << w) - 1) + 1);
    endfunction

endpackage

// File: rtl/logs_mod_core.sv
// Modulator core: free-running period counter, latched mix level and a
// PWM / first-order sigma-delta output stage.
module logs_mod_core
    import logs_mixer_pkg::*;
#(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [K-1:0] sat_c,
    input  logic         mode,
    output logic         period_start,
    output logic         audio_out
);

    logic [K-1:0] counter;
    logic [K-1:0] level;
    logic [K-1:0] acc;
    logic [K:0]   acc_sum;
    logic         wrap;

    assign wrap    = (counter == '1);
    assign acc_sum = {1'b0, acc} + {1'b0, level};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter      <= '0;
            level        <= '0;
            acc          <= '0;
            period_start <= 1'b0;
            audio_out    <= 1'b0;
        end else begin
            counter      <= counter + K'(1);
            period_start <= wrap;
            case (mode)
                MODE_SD: begin
                    level     <= sat_c;
                    acc       <= acc_sum[K-1:0];
                    audio_out <= acc_sum[K];
                end
                default: begin
                    // Level only moves at the wrap so a period's duty never changes mid-way.
                    if (wrap) begin
                        level <= sat_c;
                    end
                    acc       <= '0;
                    audio_out <= (counter < level);
                end
            endcase
        end
    end

endmodule

// File: rtl/logs_mixer_wt.sv
// Weighted N-channel mixer: per-line gain file, masked weighted sum clamped
// to the modulator full scale, driving a single-bit PWM / sigma-delta output.
module logs_mixer_wt
    import logs_mixer_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 2,
    parameter int K         = 4,
    parameter int AW        = ($clog2(N) > 1) ? $clog2(N) : 1,
    parameter int SUM_WIDTH = sum_width(N, W)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  audio_in,
    input  logic [N-1:0]  audio_mask,
    input  logic          mode,
    input  logic          gain_we,
    input  logic [AW-1:0] gain_addr,
    input  logic [W-1:0]  gain_data,
    output logic          period_start,
    output logic          audio_out
);

    localparam logic [K-1:0] FULL_SCALE = '1;

    logic [W-1:0]         gain [N];
    logic [SUM_WIDTH-1:0] sum_c;
    logic [K-1:0]         sat_c;

    // Decoding per entry means addresses beyond N-1 simply match nothing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                gain[i] <= W'(GAIN_RST);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (gain_we && (gain_addr == AW'(i))) begin
                    gain[i] <= gain_data;
                end
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N; i++) begin
            if (audio_in[i] && audio_mask[i]) begin
                sum_c = sum_c + SUM_WIDTH'(gain[i]);
            end
        end
    end

    generate
        if (SUM_WIDTH > K) begin : g_clamp
            assign sat_c = (sum_c > SUM_WIDTH'(FULL_SCALE)) ? FULL_SCALE : sum_c[K-1:0];
        end else begin : g_extend
            assign sat_c = K'(sum_c);
        end
    endgenerate

    logs_mod_core #(
        .K (K)
    ) u_mod_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .sat_c        (sat_c),
        .mode         (mode),
        .period_start (period_start),
        .audio_out    (audio_out)
    );

endmodule

// File: tb/tb_logs_mixer_wt.sv
// Directed bench for logs_mixer_wt: a main N=4/W=2/K=4 instance plus a K=3
// instance (clamping) and an N=3 instance (out-of-range gain writes).
module tb_logs_mixer_wt;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] audio_in;
    logic [3:0] audio_mask;
    logic       mode;
    logic       gain_we;
    logic [1:0] gain_addr;
    logic [1:0] gain_data;

    logic ps_main, out_main, ps_k3, out_k3, ps_n3, out_n3;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    logs_mixer_wt #(.N(4), .W(2), .K(4)) dut (
        .clk(clk), .reset_n(reset_n), .audio_in(audio_in), .audio_mask(audio_mask),
        .mode(mode), .gain_we(gain_we), .gain_addr(gain_addr), .gain_data(gain_data),
        .period_start(ps_main), .audio_out(out_main)
    );

    logs_mixer_wt #(.N(4), .W(2), .K(3)) dut_k3 (
        .clk(clk), .reset_n(reset_n), .audio_in(audio_in), .audio_mask(audio_mask),
        .mode(mode), .gain_we(gain_we), .gain_addr(gain_addr), .gain_data(gain_data),
        .period_start(ps_k3), .audio_out(out_k3)
    );

    logs_mixer_wt #(.N(3), .W(2), .K(4)) dut_n3 (
        .clk(clk), .reset_n(reset_n), .audio_in(audio_in[2:0]), .audio_mask(audio_mask[2:0]),
        .mode(mode), .gain_we(gain_we), .gain_addr(gain_addr), .gain_data(gain_data),
        .period_start(ps_n3), .audio_out(out_n3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic write_gain(input logic [1:0] a, input logic [1:0] d);
        gain_we   = 1'b1;
        gain_addr = a;
        gain_data = d;
        tick();
        gain_we   = 1'b0;
    endtask

    task automatic to_wrap();
        tick();
        while (cyc % 16 != 0) tick();
    endtask

    task automatic window(input int n, output int om, output int ok3, output int on3, output int ps);
        om = 0; ok3 = 0; on3 = 0; ps = 0;
        repeat (n) begin
            tick();
            om  += int'(out_main);
            ok3 += int'(out_k3);
            on3 += int'(out_n3);
            ps  += int'(ps_main);
        end
    endtask

    task automatic test_reset();
        int om, ok3, on3, ps;
        reset_n = 1'b0; gain_we = 1'b0; gain_addr = '0; gain_data = '0;
        audio_in = 4'hF; audio_mask = 4'hF; mode = 1'b0;
        #3;
        total++; if (out_main !== 1'b0) $display("FAIL reset_out: got %b expected 0", out_main); else passed++;
        total++; if (ps_main !== 1'b0) $display("FAIL reset_ps: got %b expected 0", ps_main); else passed++;
        do_reset();
        window(16, om, ok3, on3, ps);
        total++; if (om !== 0) $display("FAIL reset_first_period_ones: got %0d expected 0", om); else passed++;
        total++; if (ps !== 1) $display("FAIL reset_first_period_ps: got %0d expected 1", ps); else passed++;
        window(16, om, ok3, on3, ps);
        total++; if (om !== 4) $display("FAIL reset_unity_gain_ones: got %0d expected 4", om); else passed++;
        total++; if (ps_main !== 1'b1) $display("FAIL reset_ps_high: got %b expected 1", ps_main); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if (ps_main !== 1'b0) $display("FAIL reset_async_ps: got %b expected 0", ps_main); else passed++;
    endtask

    task automatic test_pwm_basic();
        int om, ok3, on3, ps;
        audio_in = 4'b1011; audio_mask = 4'hF; mode = 1'b0;
        do_reset();
        window(16, om, ok3, on3, ps);
        total++; if (om !== 0) $display("FAIL pwm_p0_ones: got %0d expected 0", om); else passed++;
        window(16, om, ok3, on3, ps);
        total++; if (om !== 3) $display("FAIL pwm_p1_ones: got %0d expected 3", om); else passed++;
        total++; if (ps !== 1) $display("FAIL pwm_p1_ps: got %0d expected 1", ps); else passed++;
        total++; if (ok3 !== 6) $display("FAIL pwm_k3_ones: got %0d expected 6", ok3); else passed++;
        total++; if (on3 !== 2) $display("FAIL pwm_n3_ones: got %0d expected 2", on3); else passed++;
        window(16, om, ok3, on3, ps);
        total++; if (om !== 3) $display("FAIL pwm_p2_ones: got %0d expected 3", om); else passed++;
    endtask

    task automatic test_gain_write();
        int om, ok3, on3, ps;
        audio_in = 4'b0011; audio_mask = 4'hF; mode = 1'b0;
        do_reset();
        write_gain(2'd0, 2'd3);
        write_gain(2'd1, 2'd2);
        to_wrap();
        window(16, om, ok3, on3, ps);
        total++; if (om !== 5) $display("FAIL gain_main_ones: got %0d expected 5", om); else passed++;
        total++; if (on3 !== 5) $display("FAIL gain_n3_ones: got %0d expected 5", on3); else passed++;
        audio_in = 4'b0111;
        write_gain(2'd3, 2'd0);
        to_wrap();
        window(16, om, ok3, on3, ps);
        total++; if (om !== 6) $display("FAIL gain_main_after_addr3: got %0d expected 6", om); else passed++;
        total++; if (on3 !== 6) $display("FAIL gain_n3_oob_write: got %0d expected 6", on3); else passed++;
    endtask

    task automatic test_clamp();
        int om, ok3, on3, ps;
        audio_in = 4'hF; audio_mask = 4'hF; mode = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) write_gain(2'(i), 2'd3);
        to_wrap();
        window(16, om, ok3, on3, ps);
        total++; if (om !== 12) $display("FAIL clamp_main_ones: got %0d expected 12", om); else passed++;
        total++; if (ok3 !== 14) $display("FAIL clamp_k3_ones: got %0d expected 14", ok3); else passed++;
        total++; if (on3 !== 9) $display("FAIL clamp_n3_ones: got %0d expected 9", on3); else passed++;
    endtask

    task automatic test_sd();
        int om, ok3, on3, ps;
        int bad;
        logic exp_bit;
        audio_in = 4'hF; audio_mask = 4'hF; mode = 1'b1;
        do_reset();
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            exp_bit = (k >= 5) && ((k - 5) % 4 == 0);
            if (out_main !== exp_bit) bad++;
        end
        total++; if (bad !== 0) $display("FAIL sd_level4_pattern: got %0d wrong cycles expected 0", bad); else passed++;
        window(16, om, ok3, on3, ps);
        total++; if (om !== 4) $display("FAIL sd_level4_density: got %0d expected 4", om); else passed++;
        total++; if (ok3 !== 8) $display("FAIL sd_k3_level4_density: got %0d expected 8", ok3); else passed++;
        audio_mask = 4'h0;
        tick(); tick();
        window(16, om, ok3, on3, ps);
        total++; if (om !== 0) $display("FAIL sd_level0: got %0d expected 0", om); else passed++;
        for (int i = 0; i < 4; i++) write_gain(2'(i), 2'd3);
        audio_mask = 4'hF;
        tick(); tick();
        window(16, om, ok3, on3, ps);
        total++; if (om !== 12) $display("FAIL sd_level12: got %0d expected 12", om); else passed++;
        total++; if (ok3 !== 14) $display("FAIL sd_k3_level7: got %0d expected 14", ok3); else passed++;
    endtask

    task automatic test_mid_period();
        int om, ok3, on3, ps;
        int o1;
        audio_in = 4'b0001; audio_mask = 4'hF; mode = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) write_gain(2'(i), 2'd3);
        to_wrap();
        window(6, o1, ok3, on3, ps);
        audio_in = 4'b0111;
        window(10, om, ok3, on3, ps);
        total++; if (o1 + om !== 3) $display("FAIL mid_current_period: got %0d expected 3", o1 + om); else passed++;
        window(16, om, ok3, on3, ps);
        total++; if (om !== 9) $display("FAIL mid_next_period: got %0d expected 9", om); else passed++;
    endtask

    task automatic test_reset_async();
        int om, ok3, on3, ps;
        int first_ps;
        tick();
        total++; if (out_main !== 1'b1) $display("FAIL async_pre_out: got %b expected 1", out_main); else passed++;
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (out_main !== 1'b0) $display("FAIL async_out_cleared: got %b expected 0", out_main); else passed++;
        total++; if (ps_main !== 1'b0) $display("FAIL async_ps_cleared: got %b expected 0", ps_main); else passed++;
        audio_in = 4'hF; audio_mask = 4'hF;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        first_ps = -1;
        while (cyc < 40 && first_ps < 0) begin
            tick();
            if (ps_main === 1'b1) first_ps = cyc;
        end
        total++; if (first_ps !== 16) $display("FAIL async_first_ps_cycle: got %0d expected 16", first_ps); else passed++;
        window(16, om, ok3, on3, ps);
        total++; if (om !== 4) $display("FAIL async_gains_unity: got %0d expected 4", om); else passed++;
    endtask

    initial begin
        test_reset();
        test_pwm_basic();
        test_gain_write();
        test_clamp();
        test_sd();
        test_mid_period();
        test_reset_async();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
